// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared definitions for the saturating-accumulate processing
//               element: default fixed-point format, dataflow mode encoding
//               and signed range helpers used to build clamp constants.
// Contents    : c_DATA_W_DEFAULT  - default operand / partial-sum width
//               c_FRAC_W_DEFAULT  - default number of fractional bits
//               pe_mode_e         - PE_MODE_WS / PE_MODE_OS
//               fxp_max()         - largest two's-complement value of a width
//               fxp_min()         - smallest two's-complement value of a width
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int c_DATA_W_DEFAULT = 16;
    localparam int c_FRAC_W_DEFAULT = 8;

    // Dataflow mode, taken straight from the pe_mode_in pin.
    typedef enum logic {
        PE_MODE_WS = 1'b0,   // weight-stationary: psum flows through the MAC
        PE_MODE_OS = 1'b1    // output-stationary: local accumulator
    } pe_mode_e;

    // Range limits are returned at 64 bits so callers can slice them down to
    // whatever width they need without a width-dependent return type.
    function automatic logic signed [63:0] fxp_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] fxp_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fxp_mac_sat.sv
`default_nettype none
// ============================================================================
// Module      : fxp_mac_sat
// Description : Combinational fixed-point multiply-add. Multiplies two signed
//               Q(DATA_W-FRAC_W).FRAC_W operands, rescales the full-precision
//               product back to the operand format (round-half-up or floor),
//               adds a signed addend and either saturates or wraps the sum.
// Ports       : op_a    in  DATA_W  multiplicand (activation)
//               op_b    in  DATA_W  multiplier (weight)
//               addend  in  DATA_W  value added to the rescaled product
//               result  out DATA_W  rescaled product + addend
//               ovf     out 1       product out of range or result clamped
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_mac_sat
    import pe_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEFAULT,
    parameter int FRAC_W   = c_FRAC_W_DEFAULT,
    parameter int SAT_EN   = 1,
    parameter int ROUND_EN = 1
) (
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] addend,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    localparam int c_PROD_W = 2 * DATA_W;
    // One guard bit above the product so the rounding constant can never
    // carry into the sign.
    localparam int c_EXT_W  = c_PROD_W + 1;
    localparam int c_SUM_W  = DATA_W + 2;

    localparam logic signed [63:0] c_MAX_64 = fxp_max(DATA_W);
    localparam logic signed [63:0] c_MIN_64 = fxp_min(DATA_W);
    localparam logic [DATA_W-1:0]  c_MAX    = c_MAX_64[DATA_W-1:0];
    localparam logic [DATA_W-1:0]  c_MIN    = c_MIN_64[DATA_W-1:0];
    localparam logic [c_EXT_W-1:0] c_HALF   = c_EXT_W'(1) << (FRAC_W - 1);

    logic signed [c_PROD_W-1:0] w_prod;
    logic [c_EXT_W-1:0]         w_prod_ext;
    logic [c_EXT_W-1:0]         w_prod_rnd;
    logic [c_EXT_W-1:0]         w_scaled;
    logic [c_EXT_W-DATA_W:0]    w_scaled_hi;
    logic                       w_prod_oor;
    logic [DATA_W-1:0]          w_term;
    logic [c_SUM_W-1:0]         w_sum;
    logic [2:0]                 w_sum_hi;
    logic                       w_sum_oor;

    assign w_prod     = $signed(op_a) * $signed(op_b);
    assign w_prod_ext = {w_prod[c_PROD_W-1], w_prod};

    generate
        if (ROUND_EN != 0) begin : g_round
            // Adding half an LSB before the floor shift gives round-half-up.
            assign w_prod_rnd = w_prod_ext + c_HALF;
        end else begin : g_trunc
            assign w_prod_rnd = w_prod_ext;
        end
    endgenerate

    assign w_scaled = $unsigned($signed(w_prod_rnd) >>> FRAC_W);

    // The rescaled product fits DATA_W only if every bit from DATA_W-1 up is
    // a copy of the sign.
    assign w_scaled_hi = w_scaled[c_EXT_W-1:DATA_W-1];
    assign w_prod_oor  = ~((&w_scaled_hi) | ~(|w_scaled_hi));

    generate
        if (SAT_EN != 0) begin : g_sat
            // An out-of-range product is pinned to the format limit before the
            // add, so the DATA_W+2 adder never sees a truncated magnitude.
            assign w_term = w_prod_oor ? (w_scaled[c_EXT_W-1] ? c_MIN : c_MAX)
                                       : w_scaled[DATA_W-1:0];
        end else begin : g_wrap
            assign w_term = w_scaled[DATA_W-1:0];
        end
    endgenerate

    assign w_sum = {{2{w_term[DATA_W-1]}}, w_term}
                 + {{2{addend[DATA_W-1]}}, addend};

    assign w_sum_hi  = w_sum[c_SUM_W-1:DATA_W-1];
    assign w_sum_oor = ~((&w_sum_hi) | ~(|w_sum_hi));

    generate
        if (SAT_EN != 0) begin : g_sat_out
            assign result = w_sum_oor ? (w_sum[c_SUM_W-1] ? c_MIN : c_MAX)
                                      : w_sum[DATA_W-1:0];
            assign ovf    = w_prod_oor | w_sum_oor;
        end else begin : g_wrap_out
            // Wrapping never clamps; only an unrepresentable product counts.
            assign result = w_sum[DATA_W-1:0];
            assign ovf    = w_prod_oor | (w_sum_oor & 1'b0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pe_sat_acc.sv
`default_nettype none
// ============================================================================
// Module      : pe_sat_acc
// Description : Systolic-array processing element with double-buffered
//               weights and a saturating fixed-point MAC. In weight-stationary
//               mode the incoming partial sum is accumulated and passed south;
//               in output-stationary mode results build up in a local
//               accumulator that is emitted on drain. Activations, valid and
//               bank-switch travel east, weights and load strobes travel
//               south. Every output is registered (one cycle latency).
// Ports       : clk              in  1       clock, rising edge
//               rst              in  1       asynchronous active-high reset
//               pe_enabled       in  1       0 = freeze all state
//               pe_valid_in/out  in/out 1    activation valid (east)
//               pe_input_in/out  in/out W    activation (east)
//               pe_accept_w_in/out in/out 1  weight load strobe (south)
//               pe_weight_in/out in/out W    weight (south)
//               pe_switch_in/out in/out 1    weight bank swap (east)
//               pe_mode_in       in  1       0 = WS, 1 = OS
//               pe_drain_in      in  1       OS: emit and clear accumulator
//               pe_psum_in/out   in/out W    partial sum (north -> south)
//               pe_ovf_out       out 1       sticky overflow
// Revision    : 1.0 - initial release
// ============================================================================
module pe_sat_acc
    import pe_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEFAULT,
    parameter int FRAC_W   = c_FRAC_W_DEFAULT,
    parameter int SAT_EN   = 1,
    parameter int ROUND_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pe_enabled,
    input  logic              pe_valid_in,
    output logic              pe_valid_out,
    input  logic [DATA_W-1:0] pe_input_in,
    output logic [DATA_W-1:0] pe_input_out,
    input  logic              pe_accept_w_in,
    output logic              pe_accept_w_out,
    input  logic [DATA_W-1:0] pe_weight_in,
    output logic [DATA_W-1:0] pe_weight_out,
    input  logic              pe_switch_in,
    output logic              pe_switch_out,
    input  logic              pe_mode_in,
    input  logic              pe_drain_in,
    input  logic [DATA_W-1:0] pe_psum_in,
    output logic [DATA_W-1:0] pe_psum_out,
    output logic              pe_ovf_out
);

    pe_mode_e          w_mode;
    logic              w_is_os;
    logic [DATA_W-1:0] w_addend;
    logic [DATA_W-1:0] w_mac;
    logic              w_mac_ovf;

    logic              r_valid_out;
    logic [DATA_W-1:0] r_input_out;
    logic              r_accept_w_out;
    logic [DATA_W-1:0] r_weight_out;
    logic              r_switch_out;
    logic [DATA_W-1:0] r_psum_out;
    logic              r_ovf;
    logic [DATA_W-1:0] r_weight_inactive;
    logic [DATA_W-1:0] r_weight_active;
    logic [DATA_W-1:0] r_acc;

    assign w_mode  = pe_mode_e'(pe_mode_in);
    assign w_is_os = (w_mode == PE_MODE_OS);

    // A single MAC serves both dataflows; only the addend differs. A drain
    // restarts the accumulator, so the product is added to zero then.
    always_comb begin
        w_addend = pe_psum_in;
        if (w_is_os) begin
            w_addend = pe_drain_in ? '0 : r_acc;
        end
    end

    fxp_mac_sat #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .SAT_EN   (SAT_EN),
        .ROUND_EN (ROUND_EN)
    ) u_mac (
        .op_a   (pe_input_in),
        .op_b   (r_weight_active),
        .addend (w_addend),
        .result (w_mac),
        .ovf    (w_mac_ovf)
    );

    // ------------------------------------------------------------------
    // Forwarding registers (east and south neighbours)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_out    <= 1'b0;
            r_input_out    <= '0;
            r_accept_w_out <= 1'b0;
            r_weight_out   <= '0;
            r_switch_out   <= 1'b0;
        end else if (pe_enabled) begin
            r_valid_out    <= pe_valid_in;
            r_input_out    <= pe_input_in;
            r_accept_w_out <= pe_accept_w_in;
            r_weight_out   <= pe_accept_w_in ? pe_weight_in : '0;
            r_switch_out   <= pe_switch_in;
        end
    end

    // ------------------------------------------------------------------
    // Weight double buffer. A swap promotes the inactive value held before
    // this edge, so a load in the same cycle lands only in the inactive bank.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_weight_inactive <= '0;
            r_weight_active   <= '0;
        end else if (pe_enabled) begin
            if (pe_accept_w_in) begin
                r_weight_inactive <= pe_weight_in;
            end
            if (pe_switch_in) begin
                r_weight_active <= r_weight_inactive;
            end
        end
    end

    // ------------------------------------------------------------------
    // Partial-sum output and OS accumulator. Drain is meaningful only in OS;
    // the accumulator is left untouched in WS so a later return to OS
    // resumes where it stopped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psum_out <= '0;
            r_acc      <= '0;
        end else if (pe_enabled) begin
            if (!w_is_os) begin
                r_psum_out <= pe_valid_in ? w_mac : '0;
            end else if (pe_drain_in) begin
                r_psum_out <= r_acc;
                r_acc      <= pe_valid_in ? w_mac : '0;
            end else begin
                r_psum_out <= pe_psum_in;
                if (pe_valid_in) begin
                    r_acc <= w_mac;
                end
            end
        end
    end

    // Sticky overflow; the MAC result is consumed only on valid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (pe_enabled && pe_valid_in && w_mac_ovf) begin
            r_ovf <= 1'b1;
        end
    end

    assign pe_valid_out    = r_valid_out;
    assign pe_input_out    = r_input_out;
    assign pe_accept_w_out = r_accept_w_out;
    assign pe_weight_out   = r_weight_out;
    assign pe_switch_out   = r_switch_out;
    assign pe_psum_out     = r_psum_out;
    assign pe_ovf_out      = r_ovf;

endmodule
`default_nettype wire

// File: doc/pe_sat_acc.md
PE_SAT_ACC -- requirements
Module: pe_sat_acc

Interface
REQ-001 SHALL expose parameter DATA_W, default 16, operand/psum width in bits (two's complement).
REQ-002 SHALL expose parameter FRAC_W, default 8, fractional bits of the fixed-point format (Q(DATA_W-FRAC_W).FRAC_W).
REQ-003 SHALL expose parameter SAT_EN, default 1, 1 = saturate result, 0 = wrap.
REQ-004 SHALL expose parameter ROUND_EN, default 1, 1 = round-half-up on rescale, 0 = truncate (floor).
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port pe_enabled  in  1  0 = hold all state and outputs.
REQ-008 SHALL have ports pe_valid_in/pe_valid_out  in/out  1  input-data valid, forwarded east.
REQ-009 SHALL have ports pe_input_in/pe_input_out  in/out  DATA_W  activation, forwarded east.
REQ-010 SHALL have ports pe_accept_w_in/pe_accept_w_out  in/out  1  weight-load strobe, forwarded south.
REQ-011 SHALL have ports pe_weight_in/pe_weight_out  in/out  DATA_W  weight, forwarded south.
REQ-012 SHALL have ports pe_switch_in/pe_switch_out  in/out  1  bank swap, forwarded east.
REQ-013 SHALL have ports pe_mode_in  in  1  0 = weight-stationary (WS), 1 = output-stationary accumulate (OS).
REQ-014 SHALL have ports pe_drain_in  in  1  OS: emit and clear accumulator.
REQ-015 SHALL have ports pe_psum_in/pe_psum_out  in/out  DATA_W  partial sum north/south.
REQ-016 SHALL have port pe_ovf_out  out  1  sticky overflow flag.

Function
REQ-017 All outputs SHALL be registered; latency input->output 1 cycle; no combinational in->out paths.
REQ-018 pe_enabled=0 SHALL freeze every register, including forwarding registers and ovf.
REQ-019 pe_accept_w_in=1: weight_inactive <= pe_weight_in; pe_weight_out <= pe_weight_in; else pe_weight_out <= 0; pe_accept_w_out <= pe_accept_w_in.
REQ-020 pe_switch_in=1: weight_active <= weight_inactive (value before this edge); simultaneous accept_w loads inactive only; pe_switch_out <= pe_switch_in.
REQ-021 MAC SHALL use weight_active value before the edge: prod = signed(input) x signed(weight_active), 2*DATA_W bits.
REQ-022 Rescale: ROUND_EN=1 add 2^(FRAC_W-1) then arithmetic shift right FRAC_W; ROUND_EN=0 shift only.
REQ-023 Addition SHALL be done at DATA_W+2 bits; SAT_EN=1 clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; SAT_EN=0 keeps low DATA_W bits.
REQ-024 Any clamp, or rescaled product outside DATA_W range, SHALL set pe_ovf_out=1 until reset.
REQ-025 WS, valid_in=1: pe_psum_out <= sat(rescale(prod)+psum_in); valid_in=0: pe_psum_out <= 0.
REQ-026 OS, valid_in=1: acc <= sat(acc+rescale(prod)); pe_psum_out <= psum_in (pass-through south).
REQ-027 OS, drain_in=1: pe_psum_out <= acc (pre-update), acc <= valid_in ? rescale(prod) : 0; drain wins over pass-through.
REQ-028 pe_input_out <= pe_input_in and pe_valid_out <= pe_valid_in every enabled cycle.
REQ-029 Mode change mid-stream SHALL NOT clear acc; drain_in ignored in WS.

Reset
REQ-030 rst=1 SHALL asynchronously clear weight_inactive, weight_active, acc, ovf and every output to 0.
REQ-031 Reset mid-operation SHALL discard in-flight data; first valid result appears 1 cycle after first valid input post-reset.

Structure
REQ-032 Shared package pe_pkg SHALL hold default DATA_W/FRAC_W, mode enum (PE_MODE_WS, PE_MODE_OS) and fixed-point min/max constants functions.
REQ-033 One sub-module fxp_mac_sat (combinational multiply, rescale, add, saturate, ovf) SHALL be reused for WS and OS paths.

Verification (DATA_W=16, FRAC_W=8)
REQ-034 Load 0x0A9A (10.6015625), switch, input 0x0200 (2.0), psum 0, WS -> psum_out 0x1534 (21.203125) 1 cycle later.
REQ-035 Active 5.75, input -3.3984375, psum 0: ROUND_EN=1 -> 0xEC76 (-19.5390625); ROUND_EN=0 -> 0xEC75 (-19.54296875).
REQ-036 Active 2.0, input 127.0, SAT_EN=1 -> psum_out 0x7FFF, ovf=1 held after; SAT_EN=0 -> 0xFE00.
REQ-037 Accept_w and switch same cycle with inactive=4.0, weight_in=6.0 -> active=4.0, inactive=6.0, weight_out=6.0.
REQ-038 OS, active 1.0, inputs 1.0,2.0,3.0 then drain -> psum_out 0x0600, acc=0; psum_in passed through meanwhile.
REQ-039 rst asserted between clock edges mid-stream -> all outputs 0 immediately, ovf cleared.
